// File: rtl/fwd_hazard_pkg.sv
// Shared types and constants for the operand-forwarding / load-use interlock unit.
//   trk_entry_t : one tracked in-flight instruction {valid, rd, we, is_load}
//   FWD_SEL_RF  : forward-select code meaning "use RegFile data"
//   stage_sel() : forward-select code for a tracker stage (stage k -> k+1)
//   cfg_ok()    : legal NSTAGES / LOAD_STAGE combination
package fwd_hazard_pkg;

  localparam int unsigned RA_W        = 5;
  localparam int unsigned FWD_SEL_W   = 3;
  localparam int unsigned NSTAGES_MIN = 1;
  localparam int unsigned NSTAGES_MAX = 6;

  localparam logic [FWD_SEL_W-1:0] FWD_SEL_RF = '0;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            we;
    logic            is_load;
  } trk_entry_t;

  function automatic logic [FWD_SEL_W-1:0] stage_sel(input int unsigned stage);
    return FWD_SEL_W'(stage + 1);
  endfunction

  function automatic bit cfg_ok(input int unsigned nstages, input int unsigned load_stage);
    return (nstages >= NSTAGES_MIN) && (nstages <= NSTAGES_MAX) && (load_stage < nstages);
  endfunction

endpackage

// File: rtl/fwd_hazard_if.sv
// Decode-side bundle of the forwarding unit.
//   slave  : the forwarding unit (takes decode/RegFile/stage data, returns operands + stall)
//   master : the pipeline side driving decode info and consuming the resolved operands
// With FWD_STATS_EN defined, stat_stall_cyc / stat_fwd_cnt are added as unit outputs.
interface fwd_hazard_if
  import fwd_hazard_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NSTAGES = 2
);

  logic                    id_valid;
  logic [RA_W-1:0]         id_rs1;
  logic [RA_W-1:0]         id_rs2;
  logic                    id_rs1_used;
  logic                    id_rs2_used;
  logic [RA_W-1:0]         id_rd;
  logic                    id_we;
  logic                    id_is_load;
  logic [XLEN-1:0]         rf_rd1;
  logic [XLEN-1:0]         rf_rd2;
  logic [NSTAGES*XLEN-1:0] stg_data;
  logic                    stall_ext;
  logic                    flush;
  logic [XLEN-1:0]         op_a;
  logic [XLEN-1:0]         op_b;
  logic [FWD_SEL_W-1:0]    fwd_sel1;
  logic [FWD_SEL_W-1:0]    fwd_sel2;
  logic                    stall_id;
  logic                    wb_we;
  logic [RA_W-1:0]         wb_rd;
`ifdef FWD_STATS_EN
  logic [31:0]             stat_stall_cyc;
  logic [31:0]             stat_fwd_cnt;
`endif

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_we, id_is_load,
    input  rf_rd1, rf_rd2, stg_data, stall_ext, flush,
`ifdef FWD_STATS_EN
    output stat_stall_cyc, stat_fwd_cnt,
`endif
    output op_a, op_b, fwd_sel1, fwd_sel2, stall_id, wb_we, wb_rd
  );

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_we, id_is_load,
    output rf_rd1, rf_rd2, stg_data, stall_ext, flush,
`ifdef FWD_STATS_EN
    input  stat_stall_cyc, stat_fwd_cnt,
`endif
    input  op_a, op_b, fwd_sel1, fwd_sel2, stall_id, wb_we, wb_rd
  );

endinterface

// File: rtl/fwd_match_mux.sv
// One operand's forwarding path: per-stage comparators, youngest-wins priority,
// load-readiness check and the operand data mux.
//   i_trk        tracker entries, index 0 = youngest (X stage)
//   i_rs/i_used  source address and whether the instruction reads it
//   i_rf_rd      RegFile read data for this source
//   i_stg_data   per-stage results, stage i at [i*XLEN +: XLEN]
//   o_op         resolved operand
//   o_sel        0 = RegFile, k = stage k-1
//   o_not_ready  winning producer is a load whose data is not yet available
module fwd_match_mux
  import fwd_hazard_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NSTAGES    = 2,
  parameter int unsigned LOAD_STAGE = 1
) (
  input  trk_entry_t [NSTAGES-1:0] i_trk,
  input  logic [RA_W-1:0]          i_rs,
  input  logic                     i_used,
  input  logic [XLEN-1:0]          i_rf_rd,
  input  logic [NSTAGES*XLEN-1:0]  i_stg_data,
  output logic [XLEN-1:0]          o_op,
  output logic [FWD_SEL_W-1:0]     o_sel,
  output logic                     o_not_ready
);

  logic w_found;

  always_comb begin
    w_found     = 1'b0;
    o_op        = i_rf_rd;
    o_sel       = FWD_SEL_RF;
    o_not_ready = 1'b0;
    // x0 is hard-wired zero, so it must always come through the RegFile path.
    for (int i = 0; i < NSTAGES; i++) begin
      if (!w_found && i_used && (i_rs != '0) && i_trk[i].valid && i_trk[i].we &&
          (i_trk[i].rd == i_rs)) begin
        w_found     = 1'b1;
        o_op        = i_stg_data[i*XLEN +: XLEN];
        o_sel       = stage_sel(i);
        o_not_ready = i_trk[i].is_load && (i < LOAD_STAGE);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Parametrised operand forwarding and load-use interlock for the RV32 pipeline.
// Tracks in-flight register writes over NSTAGES post-decode stages, forwards the
// youngest producer's result to decode, and stalls decode when that result is a
// load not yet available.
//   i_clk   rising-edge clock
//   i_rst   synchronous active-high reset (clears the tracker)
//   io_bus  fwd_hazard_if.slave: decode info, RegFile/stage data in; operands,
//           forward selects, stall_id and writeback info out
// Optional: define FWD_STATS_EN to add saturating stall/forward counters.
module fwd_hazard_unit
  import fwd_hazard_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NSTAGES    = 2,
  parameter int unsigned LOAD_STAGE = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  fwd_hazard_if.slave     io_bus
);

  localparam bit CfgOk = cfg_ok(NSTAGES, LOAD_STAGE);

  trk_entry_t [NSTAGES-1:0] r_trk;
  trk_entry_t               w_trk_new;
  logic                     w_nr1;
  logic                     w_nr2;
  logic                     w_stall_id;
  logic [FWD_SEL_W-1:0]     w_sel1;
  logic [FWD_SEL_W-1:0]     w_sel2;

  fwd_match_mux #(
    .XLEN       (XLEN),
    .NSTAGES    (NSTAGES),
    .LOAD_STAGE (LOAD_STAGE)
  ) u_match_rs1 (
    .i_trk       (r_trk),
    .i_rs        (io_bus.id_rs1),
    .i_used      (io_bus.id_rs1_used),
    .i_rf_rd     (io_bus.rf_rd1),
    .i_stg_data  (io_bus.stg_data),
    .o_op        (io_bus.op_a),
    .o_sel       (w_sel1),
    .o_not_ready (w_nr1)
  );

  fwd_match_mux #(
    .XLEN       (XLEN),
    .NSTAGES    (NSTAGES),
    .LOAD_STAGE (LOAD_STAGE)
  ) u_match_rs2 (
    .i_trk       (r_trk),
    .i_rs        (io_bus.id_rs2),
    .i_used      (io_bus.id_rs2_used),
    .i_rf_rd     (io_bus.rf_rd2),
    .i_stg_data  (io_bus.stg_data),
    .o_op        (io_bus.op_b),
    .o_sel       (w_sel2),
    .o_not_ready (w_nr2)
  );

  // A flushed decode slot is dead, so it can never be the cause of a stall.
  assign w_stall_id = io_bus.id_valid && !io_bus.flush && (w_nr1 || w_nr2);

  always_comb begin
    w_trk_new = '0;
    if (io_bus.id_valid && !w_stall_id && !io_bus.flush) begin
      w_trk_new.valid   = 1'b1;
      w_trk_new.rd      = io_bus.id_rd;
      w_trk_new.we      = io_bus.id_we;
      w_trk_new.is_load = io_bus.id_is_load;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      assert (CfgOk) else $fatal(1, "fwd_hazard_unit: illegal NSTAGES/LOAD_STAGE");
      r_trk <= '0;
    end else if (!io_bus.stall_ext) begin
      for (int i = 1; i < NSTAGES; i++) begin
        r_trk[i] <= r_trk[i-1];
      end
      r_trk[0] <= w_trk_new;
    end
  end

  assign io_bus.stall_id = w_stall_id;
  assign io_bus.fwd_sel1 = w_sel1;
  assign io_bus.fwd_sel2 = w_sel2;
  assign io_bus.wb_we    = r_trk[NSTAGES-1].valid && r_trk[NSTAGES-1].we;
  assign io_bus.wb_rd    = r_trk[NSTAGES-1].rd;

`ifdef FWD_STATS_EN
  logic [31:0] r_stat_stall_cyc;
  logic [31:0] r_stat_fwd_cnt;
  logic [1:0]  w_fwd_inc;
  logic [32:0] w_fwd_sum;

  always_comb begin
    w_fwd_inc = {1'b0, (w_sel1 != FWD_SEL_RF)} + {1'b0, (w_sel2 != FWD_SEL_RF)};
    w_fwd_sum = {1'b0, r_stat_fwd_cnt} + {31'd0, w_fwd_inc};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stat_stall_cyc <= '0;
      r_stat_fwd_cnt   <= '0;
    end else begin
      if (w_stall_id && !io_bus.stall_ext && (r_stat_stall_cyc != '1)) begin
        r_stat_stall_cyc <= r_stat_stall_cyc + 32'd1;
      end
      r_stat_fwd_cnt <= w_fwd_sum[32] ? '1 : w_fwd_sum[31:0];
    end
  end

  assign io_bus.stat_stall_cyc = r_stat_stall_cyc;
  assign io_bus.stat_fwd_cnt   = r_stat_fwd_cnt;
`endif

endmodule
